// File: rtl/aes128_iter_ctrl.sv
// Iterative AES-128 engine: accepts one block/key/mode, runs it through a single
// shared round datapath over NR+1 cycles and holds the result until it is taken.
module aes128_iter_ctrl #(
    parameter int NR     = 10,
    parameter int RIDX_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_mode,
    input  logic [127:0]      in_block,
    input  logic [127:0]      in_key,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [127:0]      out_block,
    output logic              busy,
    output logic [RIDX_W-1:0] round_idx
);

    localparam int KW = 128 * (NR + 1);

    if (NR != 10) begin : g_nr_check
        $error("aes128_iter_ctrl: only NR=10 (AES-128) is supported");
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (a^(2^k-1) built up, then one final square).
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] p;
        p = a;
        for (int i = 0; i < 6; i++) p = gmul(gmul(p, p), a);
        return gmul(p, p);
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
        return 8'((a << n) | (a >> (8 - n)));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] i;
        i = ginv(a);
        return i ^ rotl8(i, 1) ^ rotl8(i, 2) ^ rotl8(i, 3) ^ rotl8(i, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        return ginv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++)
            o[127-8*i -: 8] = inv ? inv_sbox(s[127-8*i -: 8]) : sbox(s[127-8*i -: 8]);
        return o;
    endfunction

    // Byte i of the block sits at row i%4, column i/4.
    function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        int           src;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                src = inv ? r + 4 * ((c + 4 - r) % 4) : r + 4 * ((c + r) % 4);
                o[127-8*(r+4*c) -: 8] = s[127-8*src -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [7:0] mcoef(input logic inv, input int j);
        case (j)
            0:       return inv ? 8'h0e : 8'h02;
            1:       return inv ? 8'h0b : 8'h03;
            2:       return inv ? 8'h0d : 8'h01;
            default: return inv ? 8'h09 : 8'h01;
        endcase
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        logic [7:0]   acc;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = '0;
                for (int k = 0; k < 4; k++)
                    acc = acc ^ gmul(mcoef(inv, (k - r + 4) % 4), s[127-8*(k+4*c) -: 8]);
                o[127-8*(r+4*c) -: 8] = acc;
            end
        end
        return o;
    endfunction

    // Round key r lives at bits [r*128 +: 128].
    function automatic logic [KW-1:0] key_expand(input logic [127:0] key);
        logic [31:0]   w [0:4*(NR+1)-1];
        logic [31:0]   t;
        logic [7:0]    rcon;
        logic [KW-1:0] o;
        rcon = 8'h01;
        o    = '0;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 4 * (NR + 1); i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox(t[23:16]) ^ rcon, sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])};
                rcon = gmul(rcon, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= NR; r++)
            o[r*128 +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return o;
    endfunction

    // state   | meaning
    // IDLE    | ready, waiting for a request
    // INIT    | initial AddRoundKey
    // ROUND   | full rounds 1..NR-1
    // FINAL   | last round, result registered
    // HOLD    | result presented until out_ready
    typedef enum logic [2:0] {S_IDLE, S_INIT, S_ROUND, S_FINAL, S_HOLD} state_t;

    state_t              r_fsm;
    logic [127:0]        r_state;
    logic [127:0]        r_key;
    logic                r_mode;
    logic                r_out_valid;
    logic [127:0]        r_out_block;
    logic [RIDX_W-1:0]   r_round_idx;

    logic [KW-1:0]       w_keys;
    logic [RIDX_W-1:0]   w_kidx;
    logic [127:0]        w_rk;
    logic [127:0]        w_enc_sr;
    logic [127:0]        w_dec_sr;
    logic [127:0]        w_round;
    logic [127:0]        w_last;

    assign w_keys = key_expand(r_key);

    // round_idx is 0 in INIT and NR in FINAL, so one index formula covers every state.
    assign w_kidx   = r_mode ? RIDX_W'(NR) - r_round_idx : r_round_idx;
    assign w_rk     = w_keys[w_kidx*128 +: 128];
    assign w_enc_sr = shift_rows(sub_bytes(r_state, 1'b0), 1'b0);
    assign w_dec_sr = sub_bytes(shift_rows(r_state, 1'b1), 1'b1);
    assign w_round  = r_mode ? mix_columns(w_dec_sr ^ w_rk, 1'b1)
                             : mix_columns(w_enc_sr, 1'b0) ^ w_rk;
    assign w_last   = (r_mode ? w_dec_sr : w_enc_sr) ^ w_rk;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm       <= S_IDLE;
            r_state     <= '0;
            r_key       <= '0;
            r_mode      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_block <= '0;
            r_round_idx <= '0;
        end else begin
            case (r_fsm)
                S_IDLE: begin
                    if (in_valid) begin
                        r_state <= in_block;
                        r_key   <= in_key;
                        r_mode  <= in_mode;
                        r_fsm   <= S_INIT;
                    end
                end
                S_INIT: begin
                    r_state     <= r_state ^ w_rk;
                    r_round_idx <= RIDX_W'(1);
                    r_fsm       <= S_ROUND;
                end
                S_ROUND: begin
                    r_state     <= w_round;
                    r_round_idx <= r_round_idx + 1'b1;
                    if (r_round_idx == RIDX_W'(NR - 1)) r_fsm <= S_FINAL;
                end
                S_FINAL: begin
                    r_out_block <= w_last;
                    r_out_valid <= 1'b1;
                    r_round_idx <= '0;
                    r_fsm       <= S_HOLD;
                end
                S_HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_fsm       <= S_IDLE;
                    end
                end
                default: r_fsm <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_fsm == S_IDLE);
    assign busy      = (r_fsm != S_IDLE);
    assign out_valid = r_out_valid;
    assign out_block = r_out_block;
    assign round_idx = r_round_idx;

endmodule

// File: tb/tb_aes128_iter_ctrl.sv
// Bench for aes128_iter_ctrl: FIPS-197 vectors, handshake/reset corner sequences and
// randomized traffic checked against a table-driven AES reference.
module tb_aes128_iter_ctrl;

    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic         in_mode;
    logic [127:0] in_block;
    logic [127:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_block;
    logic         busy;
    logic [3:0]   round_idx;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt++;

    aes128_iter_ctrl #(.NR(10), .RIDX_W(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_block(in_block), .in_key(in_key),
        .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block),
        .busy(busy), .round_idx(round_idx)
    );

    // ---------------- reference AES (lookup-table based) ----------------
    typedef logic [127:0] rk_t [0:10];
    logic [7:0] sb  [256];
    logic [7:0] isb [256];

    function automatic logic [7:0] rl8(logic [7:0] a, int n);
        return 8'((a << n) | (a >> (8 - n)));
    endfunction

    function automatic logic [7:0] gm(logic [7:0] a, logic [7:0] b);
        logic [7:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Walk the field with generator 3 and its inverse in lockstep.
    task automatic build_sbox;
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rl8(q, 1) ^ rl8(q, 2) ^ rl8(q, 3) ^ rl8(q, 4);
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
        for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);
    endtask

    function automatic rk_t expand(logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rk_t         k;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {sb[t[23:16]] ^ rc, sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]};
                rc = gm(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) k[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return k;
    endfunction

    function automatic logic [127:0] aes_ref(logic dec, logic [127:0] key, logic [127:0] blk);
        rk_t          k;
        logic [7:0]   a [16];
        logic [7:0]   t [16];
        logic [7:0]   x0, x1, x2, x3;
        logic [127:0] rkey, res;
        int           c, r;
        k    = expand(key);
        rkey = dec ? k[10] : k[0];
        for (int i = 0; i < 16; i++) a[i] = blk[127-8*i -: 8] ^ rkey[127-8*i -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) begin
                r = i % 4;
                c = i / 4;
                t[i] = dec ? isb[a[r + 4*((c + 4 - r) % 4)]] : sb[a[r + 4*((c + r) % 4)]];
            end
            rkey = dec ? k[10-rnd] : k[rnd];
            if (dec) for (int i = 0; i < 16; i++) t[i] = t[i] ^ rkey[127-8*i -: 8];
            a = t;
            if (rnd < 10) begin
                for (int cc = 0; cc < 4; cc++) begin
                    x0 = t[4*cc]; x1 = t[4*cc+1]; x2 = t[4*cc+2]; x3 = t[4*cc+3];
                    if (!dec) begin
                        a[4*cc]   = gm(x0, 2) ^ gm(x1, 3) ^ x2 ^ x3;
                        a[4*cc+1] = x0 ^ gm(x1, 2) ^ gm(x2, 3) ^ x3;
                        a[4*cc+2] = x0 ^ x1 ^ gm(x2, 2) ^ gm(x3, 3);
                        a[4*cc+3] = gm(x0, 3) ^ x1 ^ x2 ^ gm(x3, 2);
                    end else begin
                        a[4*cc]   = gm(x0, 14) ^ gm(x1, 11) ^ gm(x2, 13) ^ gm(x3, 9);
                        a[4*cc+1] = gm(x0, 9) ^ gm(x1, 14) ^ gm(x2, 11) ^ gm(x3, 13);
                        a[4*cc+2] = gm(x0, 13) ^ gm(x1, 9) ^ gm(x2, 14) ^ gm(x3, 11);
                        a[4*cc+3] = gm(x0, 11) ^ gm(x1, 13) ^ gm(x2, 9) ^ gm(x3, 14);
                    end
                end
            end
            if (!dec) for (int i = 0; i < 16; i++) a[i] = a[i] ^ rkey[127-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = a[i];
        return res;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(string name, logic [127:0] got, logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk_int(string name, int got, int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(logic m, logic [127:0] k, logic [127:0] b);
        int n;
        in_mode  = m;
        in_key   = k;
        in_block = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 40) begin
            cyc();
            n++;
        end
        chk_int("accept_ready", int'(in_ready), 1);
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            cyc();
            lat++;
        end
    endtask

    typedef struct {
        logic         mode;
        logic [127:0] key;
        logic [127:0] blk;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs [3];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int           lat, k, n, bad, t1, t2, t_ov, hold;
        logic         m;
        logic [127:0] rk, rb, re;

        build_sbox();
        vecs[0] = '{1'b0, KEY_C1, PT_C1, CT_C1};
        vecs[1] = '{1'b1, KEY_C1, CT_C1, PT_C1};
        vecs[2] = '{1'b1, KEY_B,  CT_B,  PT_B};

        rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0; in_block = '0; in_key = '0;
        out_ready = 1'b0;
        cyc(); cyc();
        chk_int("rst_in_ready", int'(in_ready), 1);
        chk_int("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_block", out_block, '0);
        chk_int("rst_busy", int'(busy), 0);
        chk_int("rst_round_idx", int'(round_idx), 0);
        rst = 1'b0;
        cyc();

        // FIPS-197 vectors, consumer always ready
        out_ready = 1'b1;
        for (int v = 0; v < 3; v++) begin
            do_req(vecs[v].mode, vecs[v].key, vecs[v].blk);
            in_key = '1;
            bad = 0;
            k = 0;
            while (!out_valid && k < 40) begin
                if (int'(round_idx) != ((k <= 10) ? k : 0) || !busy || in_ready) bad++;
                cyc();
                k++;
            end
            chk_int("vec_latency", k, 11);
            chk_int("vec_round_idx_seq", bad, 0);
            chk_int("vec_hold_round_idx", int'(round_idx), 0);
            chk("vec_result", out_block, vecs[v].exp);
            cyc();
            chk_int("vec_pulse_width", int'(out_valid), 0);
            chk_int("vec_in_ready_after", int'(in_ready), 1);
        end

        // back-pressure: result held 5 cycles
        out_ready = 1'b0;
        do_req(1'b0, KEY_B, PT_B);
        wait_out(lat);
        chk_int("bp_latency", lat, 11);
        bad = 0;
        for (int j = 0; j < 5; j++) begin
            chk("bp_hold_block", out_block, CT_B);
            if (!out_valid || in_ready || !busy) bad++;
            cyc();
        end
        chk_int("bp_hold_flags", bad, 0);
        chk_int("bp_still_valid", int'(out_valid), 1);
        out_ready = 1'b1;
        chk_int("bp_no_ready_before_hs", int'(in_ready), 0);
        cyc();
        chk_int("bp_valid_drop", int'(out_valid), 0);
        chk_int("bp_ready_rise", int'(in_ready), 1);

        // back-to-back with in_valid held, key changed after first accept
        in_mode = 1'b0; in_key = KEY_C1; in_block = PT_C1; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 40) begin cyc(); n++; end
        cyc();
        t1 = cyc_cnt;
        cyc();
        in_key = '1; in_mode = 1'b1; in_block = CT_C1;
        k = 1;
        while (!out_valid && k < 40) begin
            if (k == 5) in_key = KEY_C1;
            cyc();
            k++;
        end
        t_ov = cyc_cnt;
        chk_int("b2b_latency1", k, 11);
        chk("b2b_result1", out_block, CT_C1);
        cyc();
        chk_int("b2b_valid_drop", int'(out_valid), 0);
        chk_int("b2b_ready_rise", int'(in_ready), 1);
        cyc();
        t2 = cyc_cnt;
        in_valid = 1'b0;
        chk_int("b2b_accept_after_ov", t2 - t_ov, 2);
        chk_int("b2b_period", t2 - t1, 13);
        chk_int("b2b_busy2", int'(busy), 1);
        wait_out(lat);
        chk_int("b2b_latency2", lat, 11);
        chk("b2b_result2", out_block, PT_C1);
        cyc();

        // reset during round 5
        do_req(1'b0, KEY_C1, PT_C1);
        n = 0;
        while (round_idx != 4'd5 && n < 20) begin cyc(); n++; end
        chk_int("mid_reach_round5", int'(round_idx), 5);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk_int("mid_rst_in_ready", int'(in_ready), 1);
        chk_int("mid_rst_busy", int'(busy), 0);
        chk_int("mid_rst_out_valid", int'(out_valid), 0);
        chk("mid_rst_out_block", out_block, '0);
        bad = 0;
        repeat (15) begin
            if (out_valid || busy) bad++;
            cyc();
        end
        chk_int("mid_rst_no_stale", bad, 0);
        do_req(1'b0, KEY_C1, PT_C1);
        wait_out(lat);
        chk_int("mid_rst_fresh_latency", lat, 11);
        chk("mid_rst_fresh_result", out_block, CT_C1);
        cyc();

        // rst and in_valid together
        in_mode = 1'b0; in_key = KEY_B; in_block = PT_B; in_valid = 1'b1;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk_int("rstv_busy", int'(busy), 0);
        chk_int("rstv_in_ready", int'(in_ready), 1);
        cyc();
        in_valid = 1'b0;
        chk_int("rstv_accept_busy", int'(busy), 1);
        wait_out(lat);
        chk_int("rstv_latency", lat, 11);
        chk("rstv_result", out_block, CT_B);
        cyc();

        // randomized traffic with random back-pressure
        for (int it = 0; it < 25; it++) begin
            m  = 1'($urandom_range(0, 1));
            rk = {$urandom, $urandom, $urandom, $urandom};
            rb = {$urandom, $urandom, $urandom, $urandom};
            re = aes_ref(m, rk, rb);
            out_ready = 1'b0;
            repeat ($urandom_range(0, 2)) cyc();
            do_req(m, rk, rb);
            in_key   = {$urandom, $urandom, $urandom, $urandom};
            in_block = {$urandom, $urandom, $urandom, $urandom};
            in_mode  = ~m;
            wait_out(lat);
            chk_int("rnd_latency", lat, 11);
            chk("rnd_result", out_block, re);
            hold = int'($urandom_range(0, 3));
            repeat (hold) cyc();
            chk("rnd_hold_block", out_block, re);
            out_ready = 1'b1;
            cyc();
            out_ready = 1'b0;
            chk_int("rnd_release", int'(out_valid), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
